// File: rtl/fetch_sequencer.sv
// Owns the PC and fetches one instruction at a time, with at most one request outstanding.
// Build with MISALIGN_TRAP_EN to trap misaligned redirect targets instead of masking them.
module fetch_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] PC_STEP      = 32'd4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        pc_src,
   input  logic [31:0] target_address,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
`ifdef MISALIGN_TRAP_EN
   output logic        fetch_fault,
`endif
   output logic [31:0] pc
);

`ifdef MISALIGN_TRAP_EN
   typedef enum logic [2:0] {S_BOOT, S_REQ, S_WAIT, S_HOLD, S_FAULT} state_t;
`else
   typedef enum logic [2:0] {S_BOOT, S_REQ, S_WAIT, S_HOLD} state_t;
`endif

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] instr_pc_q, instr_pc_d;
   logic        instr_valid_q, instr_valid_d;
   logic        squash_q, squash_d;
   logic [31:0] tgt_aligned;
`ifdef MISALIGN_TRAP_EN
   logic        fault_q, fault_d;
`endif

   assign tgt_aligned = target_address & ~32'h3;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      squash_d      = squash_q;
`ifdef MISALIGN_TRAP_EN
      fault_d       = fault_q;
`endif
      case (state_q)
         S_BOOT: state_d = S_REQ;
         S_REQ: begin
            if (pc_src) pc_d = tgt_aligned;
            else        state_d = S_WAIT;
         end
         S_WAIT: begin
            // A redirect that coincides with the response discards it right away.
            if (pc_src) begin
               pc_d = tgt_aligned;
               if (imem_ready) begin
                  squash_d = 1'b0;
                  state_d  = S_REQ;
               end else begin
                  squash_d = 1'b1;
               end
            end else if (imem_ready) begin
               if (squash_q) begin
                  squash_d = 1'b0;
                  state_d  = S_REQ;
               end else begin
                  instr_d       = imem_rdata;
                  instr_pc_d    = pc_q;
                  instr_valid_d = 1'b1;
                  pc_d          = pc_q + PC_STEP;
                  state_d       = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (pc_src) begin
               instr_valid_d = 1'b0;
               pc_d          = tgt_aligned;
               state_d       = S_REQ;
            end else if (!stall) begin
               instr_valid_d = 1'b0;
               state_d       = S_REQ;
            end
         end
`ifdef MISALIGN_TRAP_EN
         S_FAULT: state_d = S_FAULT;
`endif
         default: state_d = S_BOOT;
      endcase
`ifdef MISALIGN_TRAP_EN
      if (pc_src && (target_address[1:0] != 2'b00) &&
          (state_q == S_REQ || state_q == S_WAIT || state_q == S_HOLD)) begin
         state_d       = S_FAULT;
         pc_d          = target_address;
         fault_d       = 1'b1;
         instr_valid_d = 1'b0;
         squash_d      = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_BOOT;
         pc_q          <= RESET_VECTOR;
         instr_q       <= 32'h0;
         instr_pc_q    <= 32'h0;
         instr_valid_q <= 1'b0;
         squash_q      <= 1'b0;
`ifdef MISALIGN_TRAP_EN
         fault_q       <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
         squash_q      <= squash_d;
`ifdef MISALIGN_TRAP_EN
         fault_q       <= fault_d;
`endif
      end
   end

   assign imem_req    = (state_q == S_REQ) && !pc_src;
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = instr_valid_q;
`ifdef MISALIGN_TRAP_EN
   assign fetch_fault = fault_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed and random checks of fetch_sequencer against a flag-level fetch model.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1, stall = 1'b0, pc_src = 1'b0, imem_ready = 1'b0;
   logic [31:0] target_address = 32'h0, imem_rdata = 32'h0;
   logic        imem_req, instr_valid;
   logic [31:0] imem_addr, instr, instr_pc, pc;
`ifdef MISALIGN_TRAP_EN
   logic        fetch_fault;
`endif

   int n_cmp = 0;
   int n_err = 0;

   // Model: booting / request outstanding / response stale / instruction held / faulted.
   bit          m_known = 0, m_boot = 0, m_out = 0, m_stale = 0, m_hold = 0, m_fault = 0;
   logic [31:0] m_pc, m_instr, m_ipc;

   fetch_sequencer dut (
      .clk(clk), .reset(reset), .stall(stall), .pc_src(pc_src),
      .target_address(target_address), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
      .instr(instr), .instr_pc(instr_pc),
`ifdef MISALIGN_TRAP_EN
      .fetch_fault(fetch_fault),
`endif
      .pc(pc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input bit r, input bit st, input bit ps, input logic [31:0] tg,
                      input bit rdy, input logic [31:0] rd);
      bit misal;
      reset = r; stall = st; pc_src = ps; target_address = tg; imem_ready = rdy; imem_rdata = rd;
      #2;
      if (m_known) begin
         chk("imem_req", imem_req, (!m_boot && !m_out && !m_hold && !m_fault && !ps));
         chk("imem_addr", imem_addr, m_pc);
         chk("pc", pc, m_pc);
         chk("instr_valid", instr_valid, m_hold);
         chk("instr", instr, m_instr);
         chk("instr_pc", instr_pc, m_ipc);
`ifdef MISALIGN_TRAP_EN
         chk("fetch_fault", fetch_fault, m_fault);
`endif
      end
      misal = 0;
`ifdef MISALIGN_TRAP_EN
      misal = (tg % 4) != 0;
`endif
      if (r) begin
         m_known = 1; m_boot = 1; m_out = 0; m_stale = 0; m_hold = 0; m_fault = 0;
         m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0;
      end else if (m_fault) begin
         m_fault = 1;
      end else if (m_boot) begin
         m_boot = 0;
      end else if (ps && misal) begin
         m_fault = 1; m_pc = tg; m_hold = 0; m_out = 0; m_stale = 0;
      end else if (ps) begin
         m_pc = tg - (tg % 4);
         m_hold = 0;
         if (m_out) begin
            if (rdy) begin m_out = 0; m_stale = 0; end
            else m_stale = 1;
         end
      end else if (m_out) begin
         if (rdy) begin
            if (!m_stale) begin
               m_instr = rd; m_ipc = m_pc; m_pc = m_pc + 4; m_hold = 1;
            end
            m_out = 0; m_stale = 0;
         end
      end else if (m_hold) begin
         if (!st) m_hold = 0;
      end else begin
         m_out = 1;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] tg, held_instr;
      // Boot
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_valid", instr_valid, 1'b0);
      chk("rst_instr", instr, 32'h0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("boot_req", imem_req, 1'b1);
      chk("boot_addr", imem_addr, 32'h0);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 32'h2001_0005);
      chk("boot_valid", instr_valid, 1'b1);
      chk("boot_instr", instr, 32'h2001_0005);
      chk("boot_ipc", instr_pc, 32'h0);
      chk("boot_pc", pc, 32'h4);
      // Stall
      held_instr = instr;
      for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, 0);
      chk("stall_valid", instr_valid, 1'b1);
      chk("stall_instr", instr, held_instr);
      cyc(0, 0, 0, 0, 0, 0);
      chk("unstall_req", imem_req, 1'b1);
      chk("unstall_addr", imem_addr, 32'h4);
      // Redirect while waiting
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 32'h100, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
      chk("squash_valid", instr_valid, 1'b0);
      chk("squash_req", imem_req, 1'b1);
      chk("squash_addr", imem_addr, 32'h100);
      // Redirect while stalled in hold
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 32'h1111_2222);
      chk("hold_valid", instr_valid, 1'b1);
      cyc(0, 1, 1, 32'h40, 0, 0);
      chk("redir_valid", instr_valid, 1'b0);
      chk("redir_addr", imem_addr, 32'h40);
      // Wrap
      cyc(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 32'h3333_4444);
      chk("wrap_pc", pc, 32'h0);
      chk("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
      // Reset mid-fetch, then a late response
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 32'h5555_6666);
      chk("late_pc", pc, 32'h0);
      chk("late_valid", instr_valid, 1'b0);
      chk("late_instr", instr, 32'h0);
      // Misaligned target
      cyc(0, 0, 1, 32'h102, 0, 0);
`ifdef MISALIGN_TRAP_EN
      chk("misal_fault", fetch_fault, 1'b1);
      chk("misal_pc", pc, 32'h102);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 32'h7);
      chk("fault_req", imem_req, 1'b0);
      chk("fault_sticky", fetch_fault, 1'b1);
`else
      chk("misal_addr", imem_addr, 32'h100);
      cyc(0, 0, 0, 0, 0, 0);
`endif
      // Random traffic
      cyc(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         tg = $urandom;
         if ($urandom_range(3) != 0) tg[1:0] = 2'b00;
         if ($urandom_range(7) == 0) tg = 32'hFFFF_FFF8 | (tg & 32'h4);
         cyc($urandom_range(63) == 0, $urandom_range(1) == 1, $urandom_range(7) == 0, tg,
             m_out ? ($urandom_range(1) == 1) : ($urandom_range(15) == 0), $urandom);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Owns the architectural PC register and sequences instruction fetch from instruction memory. Uses a single-outstanding-request handshake.
- Consumes the redirect produced by the next-PC logic (pc_src, target_address) and applies it to the PC. Squashes any in-flight fetch that the redirect makes stale.
- Presents one fetched instruction at a time to decode, with a stall back-pressure input.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  decode not ready; holds the presented instruction.
- pc_src  input  1  redirect request from next-PC logic.
- target_address  input  32  redirect target; valid when pc_src=1.
- imem_req  output  1  fetch request strobe; one cycle per request.
- imem_addr  output  32  fetch address; equals pc.
- imem_ready  input  1  response strobe from instruction memory.
- imem_rdata  input  32  instruction word; valid when imem_ready=1.
- instr_valid  output  1  instr/instr_pc hold a valid instruction.
- instr  output  32  fetched instruction word.
- instr_pc  output  32  address of instr.
- pc  output  32  current PC register.
- fetch_fault  output  1  misaligned-target fault. Only exists with MISALIGN_TRAP_EN; see Optional Feature.

Behaviour:
- States: S_BOOT, S_REQ, S_WAIT, S_HOLD, plus S_FAULT (feature only).
- Reset (synchronous, any state):
  - state=S_BOOT, pc=RESET_VECTOR.
  - instr_valid=0, instr=0, instr_pc=0, squash=0, fetch_fault=0.
  - An in-flight response arriving after reset is ignored.
- S_BOOT: unconditionally go to S_REQ next cycle. pc_src is ignored in this state.
- S_REQ:
  - imem_req = (state==S_REQ) & ~pc_src, combinational; imem_addr = pc.
  - Without redirect, go to S_WAIT.
  - With pc_src=1, no request is issued: pc <= aligned target, stay in S_REQ.
- S_WAIT:
  - Waits for imem_ready, at least 1 cycle after the request.
  - On imem_ready with squash=0 and pc_src=0:
    - instr <= imem_rdata, instr_pc <= pc, instr_valid <= 1.
    - pc <= pc + PC_STEP, mod 2^32 (0xFFFF_FFFC wraps to 0).
    - Go to S_HOLD.
  - pc_src=1 without imem_ready: pc <= target, squash <= 1, stay in S_WAIT.
  - imem_ready while squash=1, or simultaneous with pc_src: the response is discarded. squash <= 0; pc <= target if pc_src; go to S_REQ.
  - A repeated redirect while squashing updates pc again; the state stays in S_WAIT.
- S_HOLD:
  - instr_valid=1. Decode consumes the instruction in any cycle with instr_valid & ~stall.
  - stall=1: hold instr, instr_pc and instr_valid.
  - stall=0: instr_valid <= 0, go to S_REQ.
  - pc_src=1, which takes priority over stall: instr_valid <= 0, pc <= target, go to S_REQ.
- Priority: reset > pc_src > imem_ready > stall.
- imem_ready in S_BOOT, S_REQ or S_HOLD is a protocol violation and is ignored.
- Aligned target = {target_address[31:2], 2'b00}.
- Throughput: one instruction per 3 cycles minimum (REQ, WAIT with same-next-cycle ready, HOLD unstalled).

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Port fetch_fault exists.
  - A redirect with target_address[1:0] != 0, in any state that accepts pc_src, sets fetch_fault=1 and pc=target_address unmodified, and enters S_FAULT.
  - In S_FAULT: imem_req=0 and instr_valid=0; only reset exits.
  - Any in-flight response is ignored.
- Not defined:
  - No fetch_fault port and no S_FAULT state.
  - The low 2 bits of the target are silently masked to 00.

Test Plan:
- Boot: reset high 2 cycles, then low, RESET_VECTOR=0 -> imem_req=1 with imem_addr=0x0 on the 2nd cycle after reset release. Return 0x2001_0005 one cycle later -> instr_valid=1, instr_pc=0x0, pc=0x4.
- Stall: hold stall=1 for 5 cycles in S_HOLD -> instr, instr_pc and instr_valid stable, no imem_req. Release stall -> next imem_addr=0x4.
- Redirect in S_WAIT: pc_src=1 with target 0x0000_0100 while awaiting response, response 0xDEAD_BEEF 3 cycles later -> no instr_valid; next request at imem_addr=0x100.
- Redirect in S_HOLD with stall=1: target 0x40 -> instr_valid drops next cycle; next imem_addr=0x40.
- Wrap and mid-fetch reset: pc=0xFFFF_FFFC fetch completes -> pc=0x0. Assert reset in S_WAIT, then a late imem_ready -> ignored; pc=RESET_VECTOR, instr_valid=0.
- Misaligned target 0x0000_0102:
  - MISALIGN_TRAP_EN undefined -> next imem_addr=0x100.
  - MISALIGN_TRAP_EN defined -> fetch_fault=1, imem_req stays 0 until reset.
